// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with ALU, iterative shift-add multiply and EX/MEM register.
module ex_mem_stage #(
    parameter int MUL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] alu_op,
    input  logic [7:0] operand_a,
    input  logic [7:0] operand_b,
    input  logic [7:0] store_data_in,
    input  logic       read_in,
    input  logic       write_in,
    input  logic [3:0] branch_in,
    input  logic       flush,
    output logic       stall_out,
    output logic       out_valid,
    output logic [7:0] alu_result,
    output logic [7:0] Data_for_RAM,
    output logic       read,
    output logic       write,
    output logic [3:0] Branch,
    output logic       zero,
    output logic       carry
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [3:0] OP_MUL = 4'd9;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] prod_q, prod_d;
    logic [7:0]  a_q, b_q, sd_q;
    logic [3:0]  br_q;
    logic        rd_q, wr_q, cf_q, cf_d;
    logic [7:0]  r, res_d, data_d;
    logic        c, valid_d, read_d, write_d, zero_d, carry_d;
    logic [3:0]  br_d;
    logic        accept, mul_start;

    assign stall_out = state_q != IDLE;
    assign accept    = !flush && state_q == IDLE && in_valid;
    assign mul_start = accept && alu_op == OP_MUL;

    always_comb begin
        r = '0;
        c = 1'b0;
        case (alu_op)
            4'd0: {c, r} = {1'b0, operand_a} + {1'b0, operand_b};
            4'd1: begin
                r = operand_a - operand_b;
                c = operand_a < operand_b;
            end
            4'd2: r = operand_a & operand_b;
            4'd3: r = operand_a | operand_b;
            4'd4: r = operand_a ^ operand_b;
            4'd5: r = ~operand_a;
            4'd6: {c, r} = {operand_a, 1'b0};
            4'd7: {r, c} = {1'b0, operand_a};
            4'd8: r = operand_b;
            4'd10: {c, r} = {1'b0, operand_a} + {1'b0, operand_b} + {8'd0, cf_q};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (mul_start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    prod_d  = '0;
                end
                BUSY: begin
                    prod_d = prod_q + (b_q[cnt_q] ? ({8'd0, a_q} << cnt_q) : 16'd0);
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'(MUL_CYCLES - 1)) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Anything that is neither an accepted non-MUL op nor a finished MUL becomes a bubble.
    always_comb begin
        valid_d = 1'b0;
        read_d  = 1'b0;
        write_d = 1'b0;
        br_d    = '0;
        res_d   = '0;
        data_d  = '0;
        carry_d = 1'b0;
        if (accept && alu_op != OP_MUL) begin
            valid_d = 1'b1;
            read_d  = read_in;
            write_d = write_in;
            br_d    = branch_in;
            res_d   = r;
            data_d  = store_data_in;
            carry_d = c;
        end else if (!flush && state_q == DONE) begin
            valid_d = 1'b1;
            read_d  = rd_q;
            write_d = wr_q;
            br_d    = br_q;
            res_d   = prod_q[7:0];
            data_d  = sd_q;
            carry_d = |prod_q[15:8];
        end
        zero_d = valid_d && res_d == 8'd0;
        cf_d   = valid_d ? carry_d : cf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prod_q       <= '0;
            cf_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sd_q         <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            br_q         <= '0;
            out_valid    <= 1'b0;
            alu_result   <= '0;
            Data_for_RAM <= '0;
            read         <= 1'b0;
            write        <= 1'b0;
            Branch       <= '0;
            zero         <= 1'b0;
            carry        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prod_q       <= prod_d;
            cf_q         <= cf_d;
            out_valid    <= valid_d;
            alu_result   <= res_d;
            Data_for_RAM <= data_d;
            read         <= read_d;
            write        <= write_d;
            Branch       <= br_d;
            zero         <= zero_d;
            carry        <= carry_d;
            if (mul_start) begin
                a_q  <= operand_a;
                b_q  <= operand_b;
                sd_q <= store_data_in;
                rd_q <= read_in;
                wr_q <= write_in;
                br_q <= branch_in;
            end
        end
    end
endmodule
